// File: rtl/freq_ctrl_if.sv
// rtl/freq_ctrl_if.sv - datapath/switch signal bundle between freq_ctrl and its neighbours
interface freq_ctrl_if;
    logic       kcalc;
    logic       cout;
    logic [7:0] k;
    logic [2:0] n_sw;
    logic [2:0] n;
    logic       LdCnt;
    logic       counten;
    logic       fault;
    logic       locked;

    modport master (
        output kcalc, cout, k, n_sw,
        input  n, LdCnt, counten, fault, locked
    );

    modport slave (
        input  kcalc, cout, k, n_sw,
        output n, LdCnt, counten, fault, locked
    );
endinterface

// File: rtl/freq_ctrl.sv
// rtl/freq_ctrl.sv - ref_clk-domain synthesiser control FSM; lock detect enabled by FREQ_CTRL_LOCK_EN
module freq_ctrl #(
    parameter int LOCK_CNT = 4,
    parameter int LOCK_TOL = 1
) (
    input  logic          ref_clk,
    input  logic          rst,
    freq_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        LOAD  = 3'd2,
        COUNT = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       kcalc_q;
    logic [2:0] n_s1_q;
    logic [2:0] n_s_q;
    logic [2:0] n_q, n_d;
    logic       fault_q, fault_d;
    logic       krise;
    logic       nchg;
    logic       k_bad;

    assign krise = bus.kcalc & ~kcalc_q;
    assign nchg  = (n_s_q != n_q);
    assign k_bad = (bus.k < 8'd2);

    // kcalc edge-detect history and two-flop capture of the switch selector
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            kcalc_q <= 1'b0;
            n_s1_q  <= 3'd0;
            n_s_q   <= 3'd0;
        end else begin
            kcalc_q <= bus.kcalc;
            n_s1_q  <= bus.n_sw;
            n_s_q   <= n_s1_q;
        end
    end

    // FSM state register
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; in COUNT a new measurement outranks reload, which outranks a selector change
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (krise) state_d = CHECK;
            CHECK: state_d = k_bad ? FAULT : LOAD;
            LOAD:  state_d = COUNT;
            COUNT: begin
                if (krise)         state_d = CHECK;
                else if (bus.cout) state_d = LOAD;
                else if (nchg)     state_d = CHECK;
            end
            FAULT: if (krise) state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    // FSM Moore outputs: load strobe only in LOAD, counting only in COUNT
    always_comb begin
        bus.LdCnt   = (state_q == LOAD);
        bus.counten = (state_q == COUNT);
    end

    // selector and fault flag only move when a measurement is judged in CHECK
    always_comb begin
        n_d     = n_q;
        fault_d = fault_q;
        if (state_q == CHECK) begin
            fault_d = k_bad;
            if (!k_bad) begin
                n_d = n_s_q;
            end
        end
    end

    // selector and fault registers
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            n_q     <= 3'd0;
            fault_q <= 1'b0;
        end else begin
            n_q     <= n_d;
            fault_q <= fault_d;
        end
    end

    assign bus.n     = n_q;
    assign bus.fault = fault_q;

`ifdef FREQ_CTRL_LOCK_EN
    localparam logic [2:0] LOCK_CNT_W = 3'(LOCK_CNT);
    localparam logic [7:0] LOCK_TOL_W = 8'(LOCK_TOL);

    logic [7:0] k_prev_q, k_prev_d;
    logic [7:0] k_diff;
    logic [2:0] match_q, match_d;
    logic       locked_q, locked_d;

    // consecutive-match counting; a bad measurement restarts the run
    always_comb begin
        k_prev_d = k_prev_q;
        match_d  = match_q;
        k_diff   = (bus.k >= k_prev_q) ? (bus.k - k_prev_q) : (k_prev_q - bus.k);
        if (state_q == CHECK) begin
            if (k_bad) begin
                match_d = 3'd0;
            end else begin
                k_prev_d = bus.k;
                if (k_diff <= LOCK_TOL_W) begin
                    match_d = (match_q >= LOCK_CNT_W) ? match_q : match_q + 3'd1;
                end else begin
                    match_d = 3'd0;
                end
            end
        end
        locked_d = (match_d == LOCK_CNT_W);
    end

    // lock-detect registers
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            k_prev_q <= 8'd0;
            match_q  <= 3'd0;
            locked_q <= 1'b0;
        end else begin
            k_prev_q <= k_prev_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

    assign bus.locked = locked_q;
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{LOCK_CNT, LOCK_TOL};
    assign bus.locked      = 1'b0;
`endif

endmodule

// File: tb/tb_freq_ctrl.sv
// tb/tb_freq_ctrl.sv - directed and randomized checks of freq_ctrl against a history-based reference model
module tb_freq_ctrl;
    localparam int LOCK_CNT = 4;
    localparam int LOCK_TOL = 1;

    logic clk = 1'b0;
    logic rst;
    freq_ctrl_if bus();

    freq_ctrl #(.LOCK_CNT(LOCK_CNT), .LOCK_TOL(LOCK_TOL)) dut (
        .ref_clk (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: what the outputs must be in the current cycle, derived from the previous cycle's events
    bit       m_chk, m_ld, m_ce, m_flt, m_lock, m_kc_prev;
    bit [2:0] m_n, m_ns1, m_ns2;
    int       m_prevk, m_streak;
    bit       cur_kc;
    bit [2:0] cur_nsw;

    task automatic model_reset();
        m_chk = 0; m_ld = 0; m_ce = 0; m_flt = 0; m_lock = 0; m_kc_prev = 0;
        m_n = 0; m_ns1 = 0; m_ns2 = 0; m_prevk = 0; m_streak = 0;
    endtask

    // apply one cycle of inputs (called just after a falling edge) and advance the model one cycle
    task automatic drive_cycle(input bit kc, input bit co, input logic [7:0] kk, input logic [2:0] nsw);
        bit krise, waiting, stay, nx_chk, nx_ld, nx_ce, nx_flt, nx_lock;
        bit [2:0] nx_n;
        int diff;
        bus.kcalc = kc; bus.cout = co; bus.k = kk; bus.n_sw = nsw;
        cur_kc = kc; cur_nsw = nsw;
        krise   = kc && !m_kc_prev;
        waiting = !m_chk && !m_ld && !m_ce;
        stay    = m_ce && !krise && !co;
        nx_chk  = (krise && (waiting || m_ce)) || (stay && (m_ns2 != m_n));
        nx_ld   = (m_chk && kk >= 2) || (m_ce && !krise && co);
        nx_ce   = m_ld || (stay && (m_ns2 == m_n));
        nx_flt  = m_chk ? (kk < 2) : m_flt;
        nx_n    = (m_chk && kk >= 2) ? m_ns2 : m_n;
        if (m_chk) begin
            if (kk < 2) begin
                m_streak = 0;
            end else begin
                diff = int'(kk) - m_prevk;
                if (diff < 0) diff = -diff;
                m_streak = (diff <= LOCK_TOL) ? m_streak + 1 : 0;
                m_prevk  = int'(kk);
            end
        end
`ifdef FREQ_CTRL_LOCK_EN
        nx_lock = (m_streak >= LOCK_CNT);
`else
        nx_lock = 1'b0;
`endif
        m_ns2 = m_ns1; m_ns1 = nsw; m_kc_prev = kc;
        m_chk = nx_chk; m_ld = nx_ld; m_ce = nx_ce; m_flt = nx_flt; m_n = nx_n; m_lock = nx_lock;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.kcalc = 0; bus.cout = 0; bus.k = 0; bus.n_sw = 0;
        cur_kc = 0; cur_nsw = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL reset_ldcnt: got %b expected 0", bus.LdCnt); end
        n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL reset_counten: got %b expected 0", bus.counten); end
        n_checks++; if (bus.n !== 3'd0)       begin n_fail++; $display("FAIL reset_n: got %0d expected 0", bus.n); end
        n_checks++; if (bus.fault !== 1'b0)   begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
        n_checks++; if (bus.locked !== 1'b0)  begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
    endtask

    task automatic test_first_load();
        drive_cycle(1, 0, 8'd20, 3'd0);
        n_checks++; if (bus.LdCnt !== 1'b0) begin n_fail++; $display("FAIL first_ld_t1: got %b expected 0", bus.LdCnt); end
        drive_cycle(1, 0, 8'd20, 3'd0);
        n_checks++; if (bus.LdCnt !== 1'b1)   begin n_fail++; $display("FAIL first_ld_t2: got %b expected 1", bus.LdCnt); end
        n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL first_ce_t2: got %b expected 0", bus.counten); end
        drive_cycle(0, 0, 8'd20, 3'd0);
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL first_ld_t3: got %b expected 0", bus.LdCnt); end
        n_checks++; if (bus.counten !== 1'b1) begin n_fail++; $display("FAIL first_ce_t3: got %b expected 1", bus.counten); end
        n_checks++; if (bus.fault !== 1'b0)   begin n_fail++; $display("FAIL first_fault: got %b expected 0", bus.fault); end
    endtask

    task automatic test_reload();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(0, 1, 8'd20, cur_nsw);
            n_checks++; if (bus.LdCnt !== 1'b1)   begin n_fail++; $display("FAIL reload_ld[%0d]: got %b expected 1", i, bus.LdCnt); end
            n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL reload_ce_low[%0d]: got %b expected 0", i, bus.counten); end
            drive_cycle(0, 0, 8'd20, cur_nsw);
            n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL reload_double[%0d]: got %b expected 0", i, bus.LdCnt); end
            n_checks++; if (bus.counten !== 1'b1) begin n_fail++; $display("FAIL reload_ce_high[%0d]: got %b expected 1", i, bus.counten); end
            drive_cycle(0, 0, 8'd20, cur_nsw);
        end
    endtask

    task automatic test_fault();
        drive_cycle(1, 0, 8'd1, cur_nsw);
        drive_cycle(1, 0, 8'd1, cur_nsw);
        n_checks++; if (bus.fault !== 1'b1)   begin n_fail++; $display("FAIL fault_set: got %b expected 1", bus.fault); end
        n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL fault_ce: got %b expected 0", bus.counten); end
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL fault_ld: got %b expected 0", bus.LdCnt); end
        drive_cycle(0, 1, 8'd1, cur_nsw);
        n_checks++; if (bus.fault !== 1'b1)   begin n_fail++; $display("FAIL fault_hold: got %b expected 1", bus.fault); end
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL fault_cout_ignored: got %b expected 0", bus.LdCnt); end
        drive_cycle(1, 0, 8'd12, cur_nsw);
        drive_cycle(1, 0, 8'd12, cur_nsw);
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b expected 0", bus.fault); end
        n_checks++; if (bus.LdCnt !== 1'b1) begin n_fail++; $display("FAIL fault_recover_ld: got %b expected 1", bus.LdCnt); end
        drive_cycle(0, 0, 8'd12, cur_nsw);
        n_checks++; if (bus.counten !== 1'b1) begin n_fail++; $display("FAIL fault_recover_ce: got %b expected 1", bus.counten); end
    endtask

    task automatic test_nchg();
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(0, 0, 8'd12, 3'd3);
            n_checks++; if (bus.n !== 3'd0) begin n_fail++; $display("FAIL nchg_hold[%0d]: got %0d expected 0", i, bus.n); end
        end
        n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL nchg_check_ce: got %b expected 0", bus.counten); end
        drive_cycle(0, 0, 8'd12, 3'd3);
        n_checks++; if (bus.n !== 3'd3)     begin n_fail++; $display("FAIL nchg_update: got %0d expected 3", bus.n); end
        n_checks++; if (bus.LdCnt !== 1'b1) begin n_fail++; $display("FAIL nchg_ld: got %b expected 1", bus.LdCnt); end
        drive_cycle(0, 0, 8'd12, 3'd3);
        n_checks++; if (bus.counten !== 1'b1) begin n_fail++; $display("FAIL nchg_resume: got %b expected 1", bus.counten); end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1, 1, 8'd30, cur_nsw);
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL simul_t1_ld: got %b expected 0", bus.LdCnt); end
        n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL simul_t1_ce: got %b expected 0", bus.counten); end
        drive_cycle(1, 0, 8'd30, cur_nsw);
        n_checks++; if (bus.LdCnt !== 1'b1) begin n_fail++; $display("FAIL simul_t2_ld: got %b expected 1", bus.LdCnt); end
        drive_cycle(0, 0, 8'd30, cur_nsw);
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL simul_t3_ld: got %b expected 0", bus.LdCnt); end
        n_checks++; if (bus.counten !== 1'b1) begin n_fail++; $display("FAIL simul_t3_ce: got %b expected 1", bus.counten); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(0, 0, 8'd30, cur_nsw);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.LdCnt !== 1'b0)   begin n_fail++; $display("FAIL rstmid_ld: got %b expected 0", bus.LdCnt); end
        n_checks++; if (bus.counten !== 1'b0) begin n_fail++; $display("FAIL rstmid_ce: got %b expected 0", bus.counten); end
        n_checks++; if (bus.n !== 3'd0)       begin n_fail++; $display("FAIL rstmid_n: got %0d expected 0", bus.n); end
        n_checks++; if (bus.fault !== 1'b0)   begin n_fail++; $display("FAIL rstmid_fault: got %b expected 0", bus.fault); end
        bus.kcalc = 0; bus.cout = 0; bus.n_sw = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive_cycle(0, 1, 8'd30, 3'd0);
        n_checks++; if (bus.LdCnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_ld: got %b expected 0", bus.LdCnt); end
        drive_cycle(1, 0, 8'd30, 3'd0);
        drive_cycle(1, 0, 8'd30, 3'd0);
        n_checks++; if (bus.LdCnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart_ld: got %b expected 1", bus.LdCnt); end
        drive_cycle(0, 0, 8'd30, 3'd0);
    endtask

    task automatic test_lock();
        logic [7:0] seq [6];
        bit exp_lock;
        seq[0] = 8'd40; seq[1] = 8'd41; seq[2] = 8'd40; seq[3] = 8'd40; seq[4] = 8'd41; seq[5] = 8'd60;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 0, seq[i], cur_nsw);
            drive_cycle(1, 0, seq[i], cur_nsw);
`ifdef FREQ_CTRL_LOCK_EN
            exp_lock = (i == 4);
`else
            exp_lock = 1'b0;
`endif
            n_checks++; if (bus.locked !== exp_lock) begin n_fail++; $display("FAIL lock_step[%0d] k=%0d: got %b expected %b", i, seq[i], bus.locked, exp_lock); end
            drive_cycle(0, 0, seq[i], cur_nsw);
            drive_cycle(0, 0, seq[i], cur_nsw);
            n_checks++; if (bus.locked !== exp_lock) begin n_fail++; $display("FAIL lock_hold[%0d]: got %b expected %b", i, bus.locked, exp_lock); end
        end
    endtask

    task automatic test_random();
        bit kc, co, prev_ld;
        logic [7:0] kk;
        logic [2:0] nsw;
        prev_ld = bus.LdCnt;
        for (int i = 0; i < 600; i++) begin
            kc  = ($urandom_range(0, 5) == 0) ? !cur_kc : cur_kc;
            co  = ($urandom_range(0, 4) == 0);
            kk  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 3)) : 8'(38 + $urandom_range(0, 3));
            nsw = ($urandom_range(0, 30) == 0) ? 3'($urandom_range(0, 7)) : cur_nsw;
            drive_cycle(kc, co, kk, nsw);
            n_checks++; if (bus.LdCnt !== m_ld)    begin n_fail++; $display("FAIL rand_ld[%0d]: got %b expected %b", i, bus.LdCnt, m_ld); end
            n_checks++; if (bus.counten !== m_ce)  begin n_fail++; $display("FAIL rand_ce[%0d]: got %b expected %b", i, bus.counten, m_ce); end
            n_checks++; if (bus.n !== m_n)         begin n_fail++; $display("FAIL rand_n[%0d]: got %0d expected %0d", i, bus.n, m_n); end
            n_checks++; if (bus.fault !== m_flt)   begin n_fail++; $display("FAIL rand_fault[%0d]: got %b expected %b", i, bus.fault, m_flt); end
            n_checks++; if (bus.locked !== m_lock) begin n_fail++; $display("FAIL rand_locked[%0d]: got %b expected %b", i, bus.locked, m_lock); end
            n_checks++; if (prev_ld && bus.LdCnt)  begin n_fail++; $display("FAIL rand_ld_twice[%0d]: got 1 expected 0", i); end
            n_checks++; if (bus.LdCnt && bus.counten) begin n_fail++; $display("FAIL rand_ld_with_ce[%0d]: got 1 expected 0", i); end
            prev_ld = bus.LdCnt;
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_reload();
        test_fault();
        test_nchg();
        test_simultaneous();
        test_reset_mid();
        test_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_ctrl.md
# freq_ctrl

Control unit for the ref_clk-domain frequency synthesiser. It sits upstream of the measurement/counter datapath: it watches the datapath's `kcalc`, `cout` and `k` outputs and drives `LdCnt`/`counten`. It also registers the user divide selector `n` so changes apply only at a reload boundary, and flags bad or unstable measurements.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive matching measurements required before `locked` rises.
- `LOCK_TOL`, default 1: maximum |k_new − k_prev| counted as a match.

Ports:
- `ref_clk`  in  1  sole clock; every register is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `kcalc`  in  1  datapath flag; 1 while the cpu_clk low phase holds a finished measurement.
- `cout`  in  1  datapath terminal-count flag (cnt == 255).
- `k`  in  8  datapath scaled half-period.
- `n_sw`  in  3  raw divide selector from switches.
- `n`  out  3  registered divide selector, fed to the datapath.
- `LdCnt`  out  1  one-cycle parallel-load strobe to the datapath counter.
- `counten`  out  1  counter enable.
- `fault`  out  1  the last measurement had k < 2; output generation is halted.
- `locked`  out  1  measurement is stable (see Configuration).

## Operation
- Reset values: state IDLE; `n`=0, `LdCnt`=0, `counten`=0, `fault`=0, `locked`=0; all internal registers 0.
- Edge detect: `kcalc_d` is a registered copy of `kcalc`. `krise` = `kcalc` & ~`kcalc_d`.
- `n_sw` passes through two flops, giving `n_s`. `nchg` = (`n_s` != `n`).
- States (Moore outputs):
  - IDLE: `LdCnt`=0, `counten`=0. On `krise`, go to CHECK.
  - CHECK: outputs 0. If k < 2, go to FAULT and set `fault`. Otherwise go to LOAD, clear `fault`, and set `n` ← `n_s`.
  - LOAD: `LdCnt`=1, `counten`=0. Always go to COUNT next.
  - COUNT: `LdCnt`=0, `counten`=1.
    - `krise` → CHECK.
    - else `cout` → LOAD (reload).
    - else `nchg` → CHECK.
    - otherwise stay.
  - FAULT: outputs 0 and `fault`=1. On `krise`, go to CHECK.
- Simultaneous events in COUNT: `krise` outranks `cout`, which outranks `nchg`. Exactly one transition is taken and exactly one `LdCnt` pulse follows.
- `n` changes only on the CHECK→LOAD transition, so the datapath never sees a mid-count selector change.
- `LdCnt` is never high in two consecutive cycles.
- `counten` is never high in the same cycle as `LdCnt`.
- Reset asserted in any state forces IDLE and the reset values immediately, asynchronously.

## Timing
- `krise` in cycle t → CHECK at t+1 → `LdCnt`=1 at t+2 → `counten`=1 from t+3.
- `cout` high in cycle t while in COUNT → `LdCnt` at t+1 → counting resumes at t+2.
  - Each output half-period is therefore (k>>1)+2 ref_clk cycles: terminal cycle plus load cycle.
- `n_sw` change → `n_s` after 2 cycles → CHECK next → `n` updates 1 cycle later, together with entry to LOAD.
- `k` is sampled only in CHECK. Because CHECK follows `krise` by one cycle, `k` is stable at that point.

## Configuration
- `FREQ_CTRL_LOCK_EN` defined:
  - An 8-bit `k_prev` register and a 3-bit match counter are instantiated.
  - On each CHECK with k ≥ 2:
    - if |k − `k_prev`| ≤ `LOCK_TOL`, the counter increments, saturating at `LOCK_CNT`;
    - otherwise the counter clears.
    - In both cases `k_prev` ← k.
  - `locked` = (counter == `LOCK_CNT`). It is registered.
  - Entering FAULT or reset clears the counter and `locked`.
- `FREQ_CTRL_LOCK_EN` undefined: no lock logic is instantiated and `locked` is constant 0.

## Test plan
- Reset release, then `kcalc` pulse with k=20 → `LdCnt` one cycle high exactly 2 cycles after `kcalc` rises, then `counten`=1, `fault`=0.
- In COUNT, pulse `cout` once → `LdCnt` next cycle, `counten` low that cycle, high again the cycle after. Repeat for 10 reloads with no double pulse.
- `kcalc` rise with k=1 → FAULT, `fault`=1, `counten`=0. Next rise with k=12 → `fault`=0, normal load.
- `n_sw` 0→3 during COUNT → `n` stays 0 for 3 cycles, becomes 3 together with entry to LOAD, and `LdCnt` follows.
- `krise` and `cout` in the same cycle → path via CHECK, single `LdCnt`. Assert `rst` mid-COUNT → all outputs 0 within the same cycle, state IDLE.
- With `FREQ_CTRL_LOCK_EN`: k sequence 40,41,40,40,41 → `locked` rises after the 5th measurement. Then k=60 → `locked` drops. Without the macro, `locked`=0 throughout.
